// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the
// instruction-memory loader.
package imem_loader_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_packer.sv
// Shifts stream bytes into a little-endian word and
// flags the word for one cycle once it is complete.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [7:0]            byte_in,
  input  logic                  byte_en,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam logic [1:0] LAST =
    2'(BYTES_PER_WORD - 1);

  logic [1:0] cnt_q;

  // Newest byte enters at the top so the first byte
  // ends up in [7:0].
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && (cnt_q == LAST);
      if (byte_en) begin
        word  <= {byte_in, word[DATA_WIDTH-1:8]};
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int IMEM_SIZE     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0]    imem_wdata,
  output logic                     core_rst,
  output logic                     load_done,
  output logic                     load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e FIN_ST = ST_CHK;
  logic [CSUM_W-1:0] csum_q;
`else
  localparam state_e FIN_ST = ST_DONE;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [15:0] len_n;
  logic        hs;
  logic        launch;
  logic        pk_clear;
  logic        pk_en;
  logic        pk_valid;
  logic [DATA_WIDTH-1:0] pk_word;

  assign hs     = in_valid && in_ready;
  assign len_n  = {in_data, len_q[7:0]};
  assign launch = start &&
    (state_q == ST_IDLE || state_q == ST_DONE ||
     state_q == ST_ERR);

  assign pk_clear = rst || launch;
  assign pk_en    = hs && (state_q == ST_DATA);

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .clear      (pk_clear),
    .byte_in    (in_data),
    .byte_en    (pk_en),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  assign in_ready =
    (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
    (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign imem_we    = pk_valid && (state_q == ST_DATA);
  assign imem_waddr = ADDRESS_WIDTH'({idx_q, 2'b00});
  assign imem_wdata = pk_word;
  assign core_rst   = (state_q != ST_DONE);
  assign load_done  = (state_q == ST_DONE);
  assign load_err   = (state_q == ST_ERR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR:
        if (start) state_d = ST_LEN_LO;
      ST_LEN_LO:
        if (hs) state_d = ST_LEN_HI;
      ST_LEN_HI:
        if (hs) begin
          if (32'(len_n) > IMEM_SIZE)
            state_d = ST_ERR;
          else if (len_n == 16'd0)
            state_d = FIN_ST;
          else
            state_d = ST_DATA;
        end
      ST_DATA:
        if (imem_we && idx_q == len_q - 16'd1)
          state_d = FIN_ST;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK:
        if (hs)
          state_d = (in_data == csum_q) ?
                    ST_DONE : ST_ERR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        len_q <= '0;
        idx_q <= '0;
      end else begin
        if (hs && state_q == ST_LEN_LO)
          len_q[7:0] <= in_data;
        if (hs && state_q == ST_LEN_HI)
          len_q[15:8] <= in_data;
        if (imem_we)
          idx_q <= idx_q + 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Covers header and payload, never the check byte.
  always_ff @(posedge clk) begin
    if (rst || launch)
      csum_q <= '0;
    else if (hs && state_q != ST_CHK)
      csum_q <= csum_q ^ in_data;
  end
`endif

endmodule
